// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory handshake and IF/ID register.
// Handles load-use stalls, ID-resolved redirects (with drain of an in-flight request) and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;

  state_t      state, state_next;
  logic [15:0] pc_next;
  logic [15:0] pending, pending_next;
  logic [15:0] instr_next;
  logic [15:0] pc_plus2_next;
  logic        valid_next;
  logic [15:0] pc_plus2;

  assign pc_plus2     = pc + 16'd2;
  // pc only moves on a completed handshake, so the address is stable while a request is outstanding.
  assign imem_addr    = pc;
  assign fetch_halted = (state == HALTED);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next    = state;
    pc_next       = pc;
    pending_next  = pending;
    instr_next    = ifid_instr;
    pc_plus2_next = ifid_pc_plus2;
    valid_next    = ifid_valid;
    imem_req      = (state != HALTED);

    if (redirect) begin
      instr_next    = NOP_INSTR;
      pc_plus2_next = '0;
      valid_next    = 1'b0;
      if (state == HALTED || imem_rdy) begin
        pc_next    = redirect_pc;
        state_next = FETCH;
      end else begin
        // The old request must still complete before the new target can be fetched.
        pending_next = redirect_pc;
        state_next   = DRAIN;
      end
    end else begin
      unique case (state)
        FETCH, WAIT: begin
          if (imem_rdy) begin
            state_next = FETCH;
            if (!stall) begin
              instr_next    = imem_data;
              pc_plus2_next = pc_plus2;
              valid_next    = 1'b1;
              if (imem_data[15:12] == HLT_OPCODE) state_next = HALTED;
              else                                pc_next    = pc_plus2;
            end
          end else begin
            state_next = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rdy) begin
            pc_next    = pending;
            state_next = FETCH;
          end
        end
        HALTED: begin
          if (!stall) begin
            instr_next    = NOP_INSTR;
            pc_plus2_next = '0;
            valid_next    = 1'b0;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      pending       <= '0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      pending       <= pending_next;
      ifid_instr    <= instr_next;
      ifid_pc_plus2 <= pc_plus2_next;
      ifid_valid    <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan walk with literal checks,
// then randomized stimulus compared every cycle against a flag-based behavioural model.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_rdy;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, ifid_valid, fetch_halted;
  logic [15:0] imem_addr, pc, ifid_instr, ifid_pc_plus2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_rdy(imem_rdy),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid(ifid_valid), .fetch_halted(fetch_halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image, word index = byte address [8:1].
  logic [15:0] mem [256];

  // Behavioural model: a fetch is either halted, draining toward a pending target, or live.
  logic [15:0] m_pc, m_instr, m_pp2, m_pend;
  logic        m_valid, m_halted, m_drain;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc_plus2", ifid_pc_plus2, m_pp2);
    check("ifid_valid", 16'(ifid_valid), 16'(m_valid));
    check("fetch_halted", 16'(fetch_halted), 16'(m_halted));
    check("imem_req", 16'(imem_req), 16'(!m_halted));
    if (!m_halted) check("imem_addr", imem_addr, m_pc);
  endtask

  task automatic model_step(input logic r, input logic s, input logic rd,
                            input logic [15:0] rpc, input logic rdy);
    logic [15:0] word;
    word = mem[m_pc[8:1]];
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pp2 = '0; m_valid = 1'b0;
      m_halted = 1'b0; m_drain = 1'b0; m_pend = '0;
    end else if (rd) begin
      m_instr = NOP_INSTR; m_pp2 = '0; m_valid = 1'b0;
      if (m_halted || rdy) begin
        m_pc = rpc; m_drain = 1'b0;
      end else begin
        m_drain = 1'b1; m_pend = rpc;
      end
      m_halted = 1'b0;
    end else if (m_halted) begin
      if (!s) begin
        m_instr = NOP_INSTR; m_pp2 = '0; m_valid = 1'b0;
      end
    end else if (m_drain) begin
      if (rdy) begin
        m_pc = m_pend; m_drain = 1'b0;
      end
    end else if (rdy && !s) begin
      m_instr = word; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
      if (word[15:12] == 4'hF) m_halted = 1'b1;
      else                     m_pc = m_pc + 16'd2;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [15:0] rpc, input logic rdy);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_rdy = rdy;
    imem_data = mem[imem_addr[8:1]];
    model_step(r, s, rd, rpc, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_rdy = 1'b0; imem_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = {4'h1, 12'(i)};
    mem[16] = 16'hF000;  // HLT at 0x20
    m_pc = '0; m_instr = '0; m_pp2 = '0; m_pend = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_drain = 1'b0;
    #1;

    // Reset
    step(1, 0, 0, 16'h0, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", 16'(ifid_valid), 16'h0);

    // Sequential hits
    step(0, 0, 0, 16'h0, 1);
    check("hit0_pp2", ifid_pc_plus2, 16'h0002);
    check("hit0_valid", 16'(ifid_valid), 16'h1);
    step(0, 0, 0, 16'h0, 1);
    check("hit2_pc", pc, 16'h0004);

    // Miss at 4 for three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 16'h0, 0);
      check("miss_addr", imem_addr, 16'h0004);
      check("miss_hold_pp2", ifid_pc_plus2, 16'h0004);
    end
    step(0, 0, 0, 16'h0, 1);
    check("miss_instr", ifid_instr, 16'h1002);
    check("miss_pc", pc, 16'h0006);

    // Stall at 8
    step(0, 0, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    check("stall_pc", pc, 16'h0008);
    check("stall_pp2", ifid_pc_plus2, 16'h0008);
    step(0, 0, 0, 16'h0, 1);
    check("stall_rel_instr", ifid_instr, 16'h1004);
    check("stall_rel_pc", pc, 16'h000A);

    // Redirect during miss at 12
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0040, 0);
    check("drain_valid", 16'(ifid_valid), 16'h0);
    check("drain_addr", imem_addr, 16'h000C);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
    check("drain_newaddr", imem_addr, 16'h0040);
    check("drain_valid2", 16'(ifid_valid), 16'h0);

    // HLT then redirect
    step(0, 0, 1, 16'h0020, 1);
    step(0, 0, 0, 16'h0, 1);
    check("hlt_halted", 16'(fetch_halted), 16'h1);
    check("hlt_pc", pc, 16'h0020);
    check("hlt_req", 16'(imem_req), 16'h0);
    step(0, 0, 0, 16'h0, 1);
    check("hlt_bubble", 16'(ifid_valid), 16'h0);
    step(0, 0, 1, 16'h0030, 0);
    check("hlt_exit", 16'(fetch_halted), 16'h0);
    check("hlt_exit_pc", pc, 16'h0030);

    // Wrap
    step(0, 0, 1, 16'hFFFE, 1);
    step(0, 0, 0, 16'h0, 1);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_pp2", ifid_pc_plus2, 16'h0000);

    // Reset while waiting; late rdy ignored
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 1);
    check("rstw_pc", pc, RESET_PC);
    check("rstw_valid", 16'(ifid_valid), 16'h0);
    step(0, 0, 0, 16'h0, 0);

    // Randomized phase
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom) & 16'hFFFE,
           ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
